// File: rtl/halut_decoder_acc_if.sv
// rtl/halut_decoder_acc_if.sv - encoder stream, LUT write and result bundle for halut_decoder_acc
interface halut_decoder_acc_if #(
    parameter int K             = 16,
    parameter int C             = 32,
    parameter int DataTypeWidth = 16,
    parameter int AccWidth      = 16,
    parameter int CAddrWidth    = $clog2(C),
    parameter int TreeDepth     = $clog2(K),
    parameter int LutAddrWidth  = CAddrWidth + TreeDepth
);
    // encoder stream
    logic [CAddrWidth-1:0]    c_addr_i;
    logic [TreeDepth-1:0]     k_addr_i;
    logic                     valid_i;
    logic                     clear_i;
    // LUT write port
    logic [LutAddrWidth-1:0]  lut_waddr_i;
    logic [DataTypeWidth-1:0] lut_wdata_i;
    logic                     lut_we_i;
    // row result
    logic [AccWidth-1:0]      result_o;
    logic                     valid_o;
    logic                     busy_o;

    modport slave (
        input  c_addr_i, k_addr_i, valid_i, clear_i,
        input  lut_waddr_i, lut_wdata_i, lut_we_i,
        output result_o, valid_o, busy_o
    );

    modport master (
        output c_addr_i, k_addr_i, valid_i, clear_i,
        output lut_waddr_i, lut_wdata_i, lut_we_i,
        input  result_o, valid_o, busy_o
    );
endinterface

// File: rtl/halut_decoder_acc.sv
// rtl/halut_decoder_acc.sv - HALUT LUT lookup and per-row accumulator; HALUT_DECODER_SAT_EN selects saturating adds
module halut_decoder_acc #(
    parameter int K             = 16,
    parameter int C             = 32,
    parameter int DataTypeWidth = 16,
    parameter int AccWidth      = 16,
    parameter int CAddrWidth    = $clog2(C),
    parameter int TreeDepth     = $clog2(K),
    parameter int LutAddrWidth  = CAddrWidth + TreeDepth
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    halut_decoder_acc_if.slave bus
);

    localparam int CntWidth = CAddrWidth + 1;
    // {c,k} addressing leaves holes when K is not a power of two, so size by address width
    localparam int LutDepth = 1 << LutAddrWidth;

    logic [DataTypeWidth-1:0] lut_mem [LutDepth];
    logic [DataTypeWidth-1:0] lut_rdata_q;
    logic [LutAddrWidth-1:0]  lut_raddr;

    logic                s1_valid_q, s1_valid_d;
    logic [AccWidth-1:0] acc_q, acc_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [AccWidth-1:0] result_q, result_d;
    logic                valid_q, valid_d;

    logic [AccWidth-1:0] entry_ext;
    logic [AccWidth-1:0] sum;
    logic                row_last;

    assign lut_raddr = {bus.c_addr_i, bus.k_addr_i};

    // LUT write port; contents survive reset
    always_ff @(posedge clk_i) begin
        if (bus.lut_we_i) begin
            lut_mem[bus.lut_waddr_i] <= bus.lut_wdata_i;
        end
    end

    // LUT synchronous read; a same-edge write lands after this read, giving read-first behaviour
    always_ff @(posedge clk_i) begin
        if (bus.valid_i) begin
            lut_rdata_q <= lut_mem[lut_raddr];
        end
    end

    assign entry_ext = AccWidth'($signed(lut_rdata_q));

`ifdef HALUT_DECODER_SAT_EN
    logic [AccWidth:0] sum_wide;

    assign sum_wide = {acc_q[AccWidth-1], acc_q} + {entry_ext[AccWidth-1], entry_ext};

    // clamp each step so the running sum never wraps; the next step continues from the clamped value
    always_comb begin
        sum = sum_wide[AccWidth-1:0];
        if (sum_wide[AccWidth] != sum_wide[AccWidth-1]) begin
            sum = sum_wide[AccWidth] ? {1'b1, {(AccWidth-1){1'b0}}}
                                     : {1'b0, {(AccWidth-1){1'b1}}};
        end
    end
`else
    assign sum = acc_q + entry_ext;
`endif

    assign row_last = s1_valid_q && (cnt_q == CntWidth'(C - 1));

    // S1 accumulate: the C-th entry closes the row and restarts acc/cnt on the same edge
    always_comb begin
        s1_valid_d = bus.valid_i && !bus.clear_i;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        if (bus.clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (s1_valid_q) begin
            if (row_last) begin
                result_d = sum;
                valid_d  = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // pipeline and accumulator state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = (cnt_q != '0) || s1_valid_q;

endmodule

// File: doc/halut_decoder_acc.md
# halut_decoder_acc

Downstream consumer of the 4-unit HALUT encoder stage. It takes the encoder's serial stream of (codebook index, prototype index, valid) and looks up one precomputed LUT entry per codebook in a local 2-port LUT memory. It accumulates the C entries into one signed partial result per encoded input row. The block emits one result per row with a single-cycle valid pulse and runs back-to-back at one codebook per cycle with no backpressure.

## Interface
- K, default 16: prototypes per codebook.
- C, default 32: codebooks per row.
- DataTypeWidth, default 16: LUT entry width, signed two's complement.
- AccWidth, default 16: accumulator/result width, signed; must be >= DataTypeWidth.
- CAddrWidth, default $clog2(C): derived, do not override.
- TreeDepth, default $clog2(K): derived, do not override.
- LutAddrWidth, default CAddrWidth+TreeDepth: derived, do not override.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- c_addr_i  input  CAddrWidth  codebook index from encoder
- k_addr_i  input  TreeDepth  prototype index from encoder
- valid_i  input  1  c_addr_i/k_addr_i valid this cycle
- clear_i  input  1  synchronous abort of current row
- lut_waddr_i  input  LutAddrWidth  LUT write address {c,k}
- lut_wdata_i  input  DataTypeWidth  LUT write data
- lut_we_i  input  1  LUT write enable
- result_o  output  AccWidth  accumulated row result
- valid_o  output  1  result_o valid, one-cycle pulse
- busy_o  output  1  row in progress or pipeline non-empty

## Operation
- LUT: C*K x DataTypeWidth, one write port and one synchronous read port. Read address is {c_addr_i, k_addr_i}. Contents are not reset.
- Same-address write and read in one cycle is read-first: the old data is returned.
- Pipeline:
  - S0: valid_i samples; the LUT read is issued and s1_valid captured.
  - S1: the LUT data is sign-extended to AccWidth and added to acc.
- cnt (CAddrWidth+1 bits) counts accepted codebooks in S1. It does not depend on c_addr order; duplicates are not checked.
- When S1 processes the C-th entry (cnt==C-1):
  - result_q <= acc+entry and valid_o pulses.
  - acc <= 0 and cnt <= 0 in the same edge, so the next row starts cleanly with no gap cycle.
- Otherwise acc <= acc+entry and cnt <= cnt+1.
- clear_i has priority over everything:
  - zeroes acc and cnt and flushes s1_valid.
  - drops a coincident valid_i.
  - does not change result_o.
  - suppresses a valid_o that would have been produced at the same edge.
- Write traffic never stalls or disturbs accumulation.
- busy_o = (cnt!=0) | s1_valid.
- Arithmetic: full-width signed add at AccWidth. Overflow handling depends on the Configuration macro.

## Timing
- Reset values: result_o=0, valid_o=0, busy_o=0. Internal acc=0, cnt=0, s1_valid=0.
- Reset asserted mid-row discards all partial state. The LUT keeps its contents.
- Latency: if valid_i is sampled at edge t for the last codebook, valid_o is high during cycle t+2 (after edge t+1) for exactly one cycle.
- result_o holds its value until the next valid_o.
- Throughput: 1 codebook/cycle; C cycles per row sustained. Consecutive rows give valid_o pulses C cycles apart.
- Gaps in valid_i are allowed and only delay completion.
- An LUT write at edge t is visible to reads issued at edge t+1 or later.

## Configuration
- HALUT_DECODER_SAT_EN defined: each add saturates to [-2^(AccWidth-1), 2^(AccWidth-1)-1]. Saturation is applied per step, and the accumulation continues from the clamped value.
- HALUT_DECODER_SAT_EN undefined: two's-complement wrap-around at AccWidth.

## Test plan
- LUT[c][k]=c for all k; stream c=0..31 with arbitrary k, back-to-back -> one valid_o pulse 2 cycles after the last valid_i, result_o=496, busy_o low afterward.
- Same LUT, c order 3,2,1,0,7,6,... with 5 random idle gaps -> result_o=496, latency measured from the last valid_i is still 2.
- Two rows back-to-back, LUT[c][k]=k; row A all k=1, row B all k=15 -> pulses exactly 32 cycles apart, result_o=32 then 480.
- clear_i asserted after 10 codebooks, then a full fresh row with LUT=1 -> no pulse for the aborted row, next result_o=32. A valid_i coincident with clear_i is ignored.
- All LUT=0x7FFF, one row -> result_o=0x7FFF with HALUT_DECODER_SAT_EN, 0xFFE0 without. Repeat with 0x8000 -> 0x8000 with the macro, 0x0000 without.
- Reset asserted after 20 codebooks -> outputs 0 immediately. A full row after release gives the correct sum, showing the LUT contents were retained.
- Write to the same address being read in the same cycle -> the old value is used.
